// File: rtl/motion_alarm_if.sv
// Signal bundle between the PIR alarm controller and its surroundings.
// The master drives enable, acknowledge and sensors; the slave (controller) drives status.
interface motion_alarm_if #(
   parameter int NUM_SENSORS = 3,
   parameter int CNT_W       = 8
);
   logic                   turn;
   logic                   stop_alarm;
   logic [NUM_SENSORS-1:0] pir_sensor;
   logic                   alarm;
   logic                   armed;
   logic [NUM_SENSORS-1:0] zone_mask;
   logic [CNT_W-1:0]       alarm_count;
   logic [2:0]             state;

   modport master (
      output turn, stop_alarm, pir_sensor,
      input  alarm, armed, zone_mask, alarm_count, state
   );

   modport slave (
      input  turn, stop_alarm, pir_sensor,
      output alarm, armed, zone_mask, alarm_count, state
   );
endinterface

// File: rtl/motion_alarm_ctrl.sv
// PIR motion alarm sequencer: arm delay, debounced detection, latched alarm, cooldown.
// Reports the zones that triggered the last alarm and a saturating alarm count.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  OFF       | system disabled, waits for turn
//  ARMING    | arm delay running, sensors ignored
//  ARMED     | watching synced sensors
//  DETECT    | sensor high, debounce in progress
//  ALARM     | alarm latched until stop_alarm
//  COOLDOWN  | post-alarm hold-off, sensors and stop_alarm ignored
module motion_alarm_ctrl #(
   parameter int NUM_SENSORS     = 3,
   parameter int ARM_DELAY       = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int COOLDOWN_CYCLES = 16,
   parameter int CNT_W           = 8,
   parameter int TIMER_W         = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   motion_alarm_if.slave  ctrl_if
);

   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_ARMING   = 3'd1,
      ST_ARMED    = 3'd2,
      ST_DETECT   = 3'd3,
      ST_ALARM    = 3'd4,
      ST_COOLDOWN = 3'd5
   } state_e;

   // Timers count down to zero; load values are "edges remaining minus one".
   localparam logic [TIMER_W-1:0] ARM_LOAD  = TIMER_W'(ARM_DELAY - 1);
   localparam logic [TIMER_W-1:0] COOL_LOAD = TIMER_W'(COOLDOWN_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DEB_LOAD  =
      TIMER_W'((DEBOUNCE_CYCLES > 1) ? (DEBOUNCE_CYCLES - 2) : 0);

   state_e                 state_q, state_d;
   logic [TIMER_W-1:0]     timer_q, timer_d;
   logic [NUM_SENSORS-1:0] sync1_q, sync2_q;
   logic [NUM_SENSORS-1:0] zone_q, zone_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   any_s;
   logic                   enter_alarm;

   assign any_s = |sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_OFF;
         timer_q <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         zone_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         sync1_q <= ctrl_if.pir_sensor;
         sync2_q <= sync1_q;
         zone_q  <= zone_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      zone_d      = zone_q;
      count_d     = count_q;
      enter_alarm = 1'b0;

      if (!ctrl_if.turn) begin
         state_d = ST_OFF;
         timer_d = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_ARMING;
               timer_d = ARM_LOAD;
            end
            ST_ARMING: begin
               if (timer_q == '0) state_d = ST_ARMED;
               else               timer_d = timer_q - TIMER_W'(1);
            end
            ST_ARMED: begin
               if (any_s) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     enter_alarm = 1'b1;
                  end else begin
                     state_d = ST_DETECT;
                     timer_d = DEB_LOAD;
                  end
               end
            end
            ST_DETECT: begin
               if (!any_s)              state_d = ST_ARMED;
               else if (timer_q == '0)  enter_alarm = 1'b1;
               else                     timer_d = timer_q - TIMER_W'(1);
            end
            ST_ALARM: begin
               if (ctrl_if.stop_alarm) begin
                  state_d = ST_COOLDOWN;
                  timer_d = COOL_LOAD;
               end
            end
            ST_COOLDOWN: begin
               if (timer_q == '0) state_d = ST_ARMED;
               else               timer_d = timer_q - TIMER_W'(1);
            end
            default: begin
               state_d = ST_OFF;
               timer_d = '0;
            end
         endcase
      end

      if (enter_alarm) begin
         state_d = ST_ALARM;
         zone_d  = sync2_q;
         if (count_q != '1) count_d = count_q + CNT_W'(1);
      end
   end

   assign ctrl_if.alarm       = (state_q == ST_ALARM);
   assign ctrl_if.armed       = (state_q == ST_ARMED) || (state_q == ST_DETECT);
   assign ctrl_if.state       = state_q;
   assign ctrl_if.zone_mask   = zone_q;
   assign ctrl_if.alarm_count = count_q;

endmodule
